// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) constant-multiply helper for the
// column-serial InvMixColumns engine.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [7:0] GF_RED = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  // Constant coefficients are at most 4 bits wide (9, b, d, e), so four
  // doublings cover every term; synthesis folds this into a byte LUT.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Block-level valid/ready bus of the InvMixColumns engine: state in, state out.
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns of one 32-bit column (s0 in the MSB byte).
module inv_mix_column_word
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);
  logic [7:0] s  [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign s[gi] = col_in[31-8*gi -: 8];

    mul_by_9 u_m9 (.a(s[gi]), .y(m9[gi]));
    mul_by_b u_mb (.a(s[gi]), .y(mb[gi]));
    mul_by_d u_md (.a(s[gi]), .y(md[gi]));
    mul_by_e u_me (.a(s[gi]), .y(me[gi]));

    // Row gi of the circulant matrix [e b d 9] rotated right by gi.
    assign col_out[31-8*gi -: 8] = me[gi] ^ mb[(gi+1)%4] ^ md[(gi+2)%4] ^ m9[(gi+3)%4];
  end
endmodule

// File: rtl/mul_by_9.sv
// GF(2^8) multiply by 0x09.
module mul_by_9
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = gf_mul_const(a, 4'h9);
endmodule

// File: rtl/mul_by_b.sv
// GF(2^8) multiply by 0x0b.
module mul_by_b
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = gf_mul_const(a, 4'hb);
endmodule

// File: rtl/mul_by_d.sv
// GF(2^8) multiply by 0x0d.
module mul_by_d
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = gf_mul_const(a, 4'hd);
endmodule

// File: rtl/mul_by_e.sv
// GF(2^8) multiply by 0x0e.
module mul_by_e
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = gf_mul_const(a, 4'he);
endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: load a state, transform one column per cycle,
// then hold the result until downstream takes it.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  inv_mix_columns_seq_if.slave bus
);
  fsm_t       state_fsm;
  state_t     state_q;
  state_t     state_next;
  logic [1:0] col_q;
  logic       out_valid_q;
  col_t       cols [4];
  col_t       col_in;
  col_t       col_out;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign cols[gi] = state_q[127-32*gi -: 32];
    assign state_next[127-32*gi -: 32] = (col_q == 2'(gi)) ? col_out : cols[gi];
  end

  assign col_in = cols[col_q];

  inv_mix_column_word u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );

  assign bus.in_ready  = (state_fsm == IDLE) | ((state_fsm == DONE) & bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_fsm   <= IDLE;
      state_q     <= '0;
      col_q       <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state_q   <= bus.in_state;
            col_q     <= 2'd0;
            state_fsm <= BUSY;
          end
        end
        BUSY: begin
          state_q <= state_next;
          col_q   <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_fsm   <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            // Output handshake and next accept share this edge.
            if (bus.in_valid) begin
              state_q   <= bus.in_state;
              col_q     <= 2'd0;
              state_fsm <= BUSY;
            end else begin
              state_fsm <= IDLE;
            end
          end
        end
        default: begin
          state_fsm   <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq; reference is forward MixColumns applied three times.
module tb_inv_mix_columns_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product then polynomial reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mix_fwd(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   b [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = s[127-32*c-8*k -: 8];
      for (int k = 0; k < 4; k++)
        r[127-32*c-8*k -: 8] = gmul(8'h02, b[k]) ^ gmul(8'h03, b[(k+1)%4]) ^ b[(k+2)%4] ^ b[(k+3)%4];
    end
    return r;
  endfunction

  // MixColumns has order 4, so its cube is the inverse.
  function automatic logic [127:0] model_inv(input logic [127:0] s);
    return mix_fwd(mix_fwd(mix_fwd(s)));
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts and ends at a falling edge; reports latency in cycles after the accept cycle.
  task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
    int k;
    bus.in_state  = din;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_state = rand128();
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    dout = bus.out_state;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_state !== 128'h0) begin
      errors++;
      $display("FAIL reset_held got rdy=%b vld=%b st=%h want rdy=1 vld=0 st=0", bus.in_ready, bus.out_valid, bus.out_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_state !== 128'h0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b st=%h want rdy=1 vld=0 st=0", bus.in_ready, bus.out_valid, bus.out_state);
    end
    @(negedge clk);
    $display("reset: checked");
  endtask

  task automatic test_vectors();
    logic [127:0] din [3];
    logic [127:0] exp [3];
    logic [127:0] got;
    int lat;
    din[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    exp[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    din[1] = 128'h0;
    exp[1] = 128'h0;
    din[2] = {4{32'h4d7ebdf8}};
    exp[2] = {4{32'h2d26314c}};
    for (int i = 0; i < 3; i++) begin
      run_block(din[i], got, lat);
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL vector%0d got %h want %h", i, got, exp[i]);
      end
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL vector%0d_latency got %0d want 5", i, lat);
      end
      $display("vector%0d: in %h out %h lat %0d", i, din[i], got, lat);
    end
  endtask

  task automatic test_random();
    logic [127:0] din;
    logic [127:0] got;
    logic [127:0] exp;
    int lat;
    for (int i = 0; i < 8; i++) begin
      din = rand128();
      exp = model_inv(din);
      run_block(din, got, lat);
      checks++;
      if (got !== exp || lat != 5) begin
        errors++;
        $display("FAIL random%0d got %h lat %0d want %h lat 5", i, got, lat, exp);
      end
      $display("random%0d: in %h out %h lat %0d", i, din, got, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] din;
    logic [127:0] exp;
    int bad;
    int k;
    din = rand128();
    exp = model_inv(din);
    bus.in_state  = din;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_state = rand128();
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk); k++;
    end
    bad = 0;
    // in_valid stays high through the stall; nothing may be accepted.
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_state !== exp || bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_stall got %0d bad cycles (st=%h) want 0 (st=%h)", bad, bus.out_state, exp);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ready got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drop got %b want 0", bus.out_valid);
    end
    @(negedge clk);
    $display("backpressure: out %h bad %0d", exp, bad);
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] got [$];
    int           at  [$];
    logic         rdy5;
    a = rand128();
    b = rand128();
    rdy5 = 1'b0;
    bus.in_state  = a;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_accept got %b want 1", bus.in_ready);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.in_state = b;
      if (c == 10) bus.in_valid = 1'b0;
      #1;
      if (c == 5) rdy5 = bus.in_ready;
      if (bus.out_valid) begin
        got.push_back(bus.out_state);
        at.push_back(c);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (rdy5 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_same_edge_accept got %b want 1", rdy5);
    end
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", got.size());
    end else begin
      checks++;
      if (at[0] != 5 || got[0] !== model_inv(a)) begin
        errors++;
        $display("FAIL b2b_first got %h at %0d want %h at 5", got[0], at[0], model_inv(a));
      end
      checks++;
      if (at[1] != 10 || got[1] !== model_inv(b)) begin
        errors++;
        $display("FAIL b2b_second got %h at %0d want %h at 10", got[1], at[1], model_inv(b));
      end
      $display("back_to_back: %h@%0d %h@%0d", got[0], at[0], got[1], at[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_input();
    logic [127:0] din;
    logic [127:0] got;
    int k;
    din = rand128();
    bus.in_state  = din;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      bus.in_state = rand128();
      bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    k = 0;
    #1;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk); #1; k++;
    end
    got = bus.out_state;
    checks++;
    if (got !== model_inv(din) || k != 0) begin
      errors++;
      $display("FAIL ignored_input got %h extra_wait %0d want %h extra_wait 0", got, k, model_inv(din));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("ignored_input: in %h out %h", din, got);
  endtask

  task automatic test_reset_mid();
    logic [127:0] din;
    logic [127:0] got;
    int lat;
    bus.in_state  = rand128();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_state !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b st=%h want rdy=1 vld=0 st=0", bus.in_ready, bus.out_valid, bus.out_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    din = rand128();
    run_block(din, got, lat);
    checks++;
    if (got !== model_inv(din) || lat != 5) begin
      errors++;
      $display("FAIL reset_mid_recover got %h lat %0d want %h lat 5", got, lat, model_inv(din));
    end
    $display("reset_mid: recover out %h lat %0d", got, lat);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
